// File: rtl/protocol_pkg.sv
// Shared protocol constants and types for the SPI front end.
package protocol_pkg;

   localparam int unsigned SPI_WORD_W      = 8;
   localparam logic [7:0]  SPI_ECHO_STATUS = 8'hA5;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchroniser for one asynchronous input, resetting to a configurable idle level.
module sync_ff #(
   parameter int unsigned Stages   = 2,
   parameter logic        ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {Stages{ResetVal}};
      end else begin
         sync_q <= {sync_q[Stages-2:0], d_i};
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// Oversampling mode-0 SPI slave receiver: deserialises WIDTH-bit words and reports frame edges.
// Optional MISO echo of the previous word is enabled by defining SPI_MISO_ECHO_EN.
module spi_frame_receiver
   import protocol_pkg::*;
#(
   parameter int unsigned WIDTH       = SPI_WORD_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             frag_error
);

   localparam int unsigned CntW       = $clog2(WIDTH + 1);
   localparam int unsigned FillCycles = SYNC_STAGES + 1;
   localparam int unsigned FillW      = $clog2(FillCycles + 1);

   logic sclk_s, cs_s, mosi_s;
   logic sclk_hist_q, cs_hist_q;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   sync_ff #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
      .clk_i  (clk),
      .rst_ni (rstn),
      .d_i    (spi_sclk),
      .q_o    (sclk_s)
   );

   sync_ff #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
      .clk_i  (clk),
      .rst_ni (rstn),
      .d_i    (spi_cs_n),
      .q_o    (cs_s)
   );

   sync_ff #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
      .clk_i  (clk),
      .rst_ni (rstn),
      .d_i    (spi_mosi),
      .q_o    (mosi_s)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b1;
      end else begin
         sclk_hist_q <= sclk_s;
         cs_hist_q   <= cs_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign cs_rise   = cs_s & ~cs_hist_q;
   assign cs_fall   = ~cs_s & cs_hist_q;

   spi_rx_state_t    state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d, shift_next;
   logic [WIDTH-1:0] word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_end_q, frame_end_d;
   logic             frag_q, frag_d;
   logic             armed_q, armed_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic             filled;

   // The synchronisers come out of reset at idle levels, so a CS_N already low would look like a
   // fresh falling edge; only arm once the real pin has been seen high through the full pipeline.
   assign filled     = (fill_q == FillW'(FillCycles));
   assign shift_next = {shift_q[WIDTH-2:0], mosi_s};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      word_d        = word_q;
      frag_d        = frag_q;
      word_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      fill_d        = filled ? fill_q : fill_q + FillW'(1);
      armed_d       = armed_q | (filled & cs_s & cs_hist_q);

      unique case (state_q)
         IDLE: begin
            if (cs_fall && armed_q) begin
               frame_start_d = 1'b1;
               cnt_d         = '0;
               shift_d       = '0;
               frag_d        = 1'b0;
               state_d       = ACTIVE;
            end
         end
         ACTIVE: begin
            // CS_N rising takes priority over a coincident SCLK edge.
            if (cs_rise) begin
               frame_end_d = 1'b1;
               if (cnt_q != '0) begin
                  frag_d = 1'b1;
               end
               cnt_d   = '0;
               shift_d = '0;
               state_d = IDLE;
            end else if (sclk_rise) begin
               shift_d = shift_next;
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  word_d       = shift_next;
                  word_valid_d = 1'b1;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shift_q       <= '0;
         word_q        <= '0;
         word_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frag_q        <= 1'b0;
         armed_q       <= 1'b0;
         fill_q        <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         word_q        <= word_d;
         word_valid_q  <= word_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         frag_q        <= frag_d;
         armed_q       <= armed_d;
         fill_q        <= fill_d;
      end
   end

   assign word_out    = word_q;
   assign word_valid  = word_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign frag_error  = frag_q;

`ifdef SPI_MISO_ECHO_EN
   // Status byte occupies the top bits so it is shifted out first.
   localparam logic [WIDTH+7:0] EchoExt  = {SPI_ECHO_STATUS, {WIDTH{1'b0}}};
   localparam logic [WIDTH-1:0] EchoInit = EchoExt[WIDTH+7:8];

   logic [WIDTH-1:0] echo_q, echo_d;
   logic             miso_q, miso_d;

   always_comb begin
      echo_d = echo_q;
      miso_d = miso_q;
      if (frame_start_d) begin
         miso_d = EchoInit[WIDTH-1];
         echo_d = EchoInit << 1;
      end else if (word_valid_d) begin
         echo_d = word_d;
      end else if (state_q == ACTIVE && !cs_rise && sclk_fall) begin
         miso_d = echo_q[WIDTH-1];
         echo_d = echo_q << 1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         echo_q <= '0;
         miso_q <= 1'b0;
      end else begin
         echo_q <= echo_d;
         miso_q <= miso_d;
      end
   end

   assign spi_miso = miso_q;
`else
   logic unused_fall;
   assign unused_fall = sclk_fall;
   assign spi_miso    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a word-queue model checked every cycle.
// Define SPI_MISO_ECHO_EN for both bench and RTL to exercise the MISO echo.
module tb_spi_frame_receiver;

   logic       clk = 1'b0;
   logic       rstn;
   logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
   logic [7:0] word_out;
   logic       word_valid, frame_start, frame_end, frag_error;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  model_last;
   int          fs_cnt = 0, fe_cnt = 0;
   int          exp_fs = 0, exp_fe = 0;
   logic [15:0] cap;

   spi_frame_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .spi_sclk    (spi_sclk),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frag_error  (frag_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every completed word must come out in order, word_out holds between words.
   always @(negedge clk) begin
      if (!rstn) begin
         chk("reset_outputs", {word_out, word_valid, frame_start, frame_end, frag_error, spi_miso},
             32'h0);
         model_last = 8'h00;
      end else begin
         if (word_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {24'h0, word_out}, 32'hFFFF_FFFF);
            end else begin
               model_last = exp_q.pop_front();
               chk("word_value", {24'h0, word_out}, {24'h0, model_last});
            end
            chk("valid_end_exclusive", {31'h0, frame_end}, 32'h0);
         end else begin
            chk("word_hold", {24'h0, word_out}, {24'h0, model_last});
         end
         if (frame_start) fs_cnt++;
         if (frame_end) fe_cnt++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      spi_mosi = b;
      wait_clks(6);
      cap      = {cap[14:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clks(6);
      spi_sclk = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] data, input int nbits);
      logic exp_frag;
      for (int k = 0; k < nbits / 8; k++) begin
         exp_q.push_back(8'((data >> (nbits - 8 * (k + 1))) & 32'hFF));
      end
      exp_fs++;
      exp_fe++;
      exp_frag = (nbits % 8) != 0;
      spi_cs_n = 1'b0;
      wait_clks(6);
      chk("frag_cleared_at_start", {31'h0, frag_error}, 32'h0);
      for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
      wait_clks(6);
      spi_cs_n = 1'b1;
      wait_clks(8);
      chk("frag_error", {31'h0, frag_error}, {31'h0, exp_frag});
      chk("frame_start_count", fs_cnt, exp_fs);
      chk("frame_end_count", fe_cnt, exp_fe);
      chk("words_drained", exp_q.size(), 0);
   endtask

   initial begin
      rstn     = 1'b1;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      cap      = '0;
      #3 rstn  = 1'b0;
      wait_clks(4);
      rstn = 1'b1;
      wait_clks(6);
      chk("post_reset_word", {24'h0, word_out}, 32'h0);
      chk("post_reset_frag", {31'h0, frag_error}, 32'h0);

      run_frame(32'h5A, 8);
      chk("lit_5a", {24'h0, word_out}, 32'h5A);

      run_frame(32'h0180FF, 24);
      chk("lit_ff_last", {24'h0, word_out}, 32'hFF);

      run_frame(32'h15, 5);
      chk("lit_frag_set", {31'h0, frag_error}, 32'h1);
      chk("lit_frag_word_held", {24'h0, word_out}, 32'hFF);
      run_frame(32'h33, 8);
      chk("lit_33", {24'h0, word_out}, 32'h33);
      chk("lit_frag_clear", {31'h0, frag_error}, 32'h0);

      // SCLK activity with CS_N high must be ignored.
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      wait_clks(8);
      chk("idle_sclk_no_start", fs_cnt, exp_fs);
      chk("idle_sclk_word_held", {24'h0, word_out}, 32'h33);

      // Reset mid-frame, then CS_N held low across reset release.
      spi_cs_n = 1'b0;
      wait_clks(6);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_clks(2);
      rstn = 1'b0;
      #1;
      chk("abort_outputs_zero",
          {word_out, word_valid, frame_start, frame_end, frag_error, spi_miso}, 32'h0);
      exp_fs = fs_cnt;
      exp_fe = fe_cnt;
      wait_clks(3);
      rstn = 1'b1;
      wait_clks(10);
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      wait_clks(8);
      chk("no_start_while_low", fs_cnt, exp_fs);
      chk("no_end_after_abort", fe_cnt, exp_fe);
      spi_cs_n = 1'b1;
      wait_clks(10);
      run_frame(32'h77, 8);
      chk("lit_77", {24'h0, word_out}, 32'h77);

`ifdef SPI_MISO_ECHO_EN
      run_frame(32'h1234, 16);
      chk("echo_bits", {16'h0, cap}, 32'hA512);
`else
      chk("miso_tied_low", {31'h0, spi_miso}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
